mcpu_ram_arbiter: RTL
=====================

Name: mcpu_ram_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port MCPU RAM controller. It shares one RAM between the instruction-fetch port (read-only) and the data port (read/write). Each granted access runs through a fixed 3-cycle sequence, and the arbiter drives the RAM strobes (we/re), address and write data from registers. It sits between the MCPU core's fetch/load-store units and the RAM controller.

Parameters:
WORD_SIZE, 8, data word width in bits
ADDR_WIDTH, 8, RAM address width in bits
RAM_SIZE, 1<<ADDR_WIDTH, RAM depth in words; informational only, no range checking

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  instruction fetch request; held high until if_ack
if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high
if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle
if_rdata  out  WORD_SIZE  fetched word; register holds its value between fetches
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = write, 0 = read; stable while d_req is high
d_addr  in  ADDR_WIDTH  data address; stable while d_req is high
d_wdata  in  WORD_SIZE  write data; stable while d_req is high
d_ack  out  1  one-cycle completion pulse for reads and writes
d_rdata  out  WORD_SIZE  read data; updated on read completion only
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_rdata  in  WORD_SIZE  RAM read data; valid one cycle after the ram_re cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous, honoured in any state including mid-access):
  - state=IDLE
  - all outputs 0: if_ack, d_ack, if_rdata, d_rdata, ram_we, ram_re, ram_addr, ram_wdata, busy
  - last_grant=DATA, so the instruction port wins the first tie
  - an access interrupted by reset is dropped: no ack is ever issued for it.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: sample requests using the masked values (see ack masking below).
  - Neither requesting: stay in IDLE.
  - Exactly one requesting: grant it.
  - Both requesting: grant the port that is not last_grant.
  - On a grant: latch the winner into gnt; update last_grant; next state ACCESS.
  - Register from the winner: ram_addr; ram_wdata (data port only); ram_we=d_we for a data grant, 0 for fetch; ram_re = the inverse of ram_we.
- ACCESS: the strobe is high for exactly this one cycle. Next state RESP; ram_we and ram_re return to 0 on entry to RESP. ram_addr and ram_wdata hold their values until the next grant.
- RESP: capture ram_rdata into if_rdata or d_rdata (reads only), per gnt. Pulse the matching ack for one cycle, coincident with the updated rdata. Next state IDLE.
- Latency: request first seen at edge k -> strobe during cycle k..k+1 -> ack high after edge k+2. Peak throughput is one access per 3 cycles.
- Ack masking: during the ack cycle the arbiter sits in IDLE and ignores the acked port's req, because the requester is still dropping it. A still-high req in the following cycle is a new request.
- Writes: d_ack pulses on the same schedule; d_rdata is unchanged; if_rdata is never modified by data accesses.
- Fairness: under continuous requests from both ports, grants strictly alternate I, D, I, D...
- No combinational path from any input to any output; all outputs are registered.
- Request input changes while not in IDLE have no effect on the access in progress.

Test Plan:
- Reset then single fetch: if_addr=0x12, RAM[0x12]=0xA5, if_req at edge 0 -> ram_re=1, ram_addr=0x12 after edge 1; if_ack=1, if_rdata=0xA5 after edge 3; busy=0 thereafter.
- Data write then read: d_we=1, d_addr=0x40, d_wdata=0x3C -> one ram_we pulse with addr=0x40, data=0x3C, then d_ack with d_rdata unchanged. A following read of 0x40 returns d_rdata=0x3C.
- Simultaneous requests held high for 4 accesses: first grant goes to fetch after reset, then grants alternate I,D,I,D. Acks arrive every 3 cycles.
- Back-to-back fetch with req held through the ack cycle: the second access starts only after the mask cycle. There are never two acks within 3 cycles.
- rst_n pulled low during ACCESS of a data write: ram_we drops immediately (asynchronous) and no d_ack is issued. After release, the arbiter is in IDLE and a new fetch completes normally.
- Randomised fetch and data mix against a 256-entry model: every fetch and read returns the model value, and each port's addresses and write data reach the RAM unchanged.

Source files
------------

// File: rtl/mcpu_ram_arbiter.sv
// Two-port round-robin arbiter and 3-cycle sequencer in front of the
// single-port MCPU RAM. The fetch port is read-only and the data port is
// read/write. Every output is a register, so there is no input-to-output
// combinational path.
module mcpu_ram_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [WORD_SIZE-1:0]  if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ack,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic [WORD_SIZE-1:0]  ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // RAM_SIZE is informational: depth beyond the address space is unreachable
  // and there is no range checking, so it generates no logic.
  if (RAM_SIZE > (1 << ADDR_WIDTH)) begin : g_depth_beyond_addr
  end

  state_t                state_q;
  logic                  gnt_data_q;   // 1 = current access belongs to data port
  logic                  last_data_q;  // 1 = most recent grant went to data port
  logic                  wr_q;         // current access is a write
  logic                  ram_we_q;
  logic                  ram_re_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [WORD_SIZE-1:0]  ram_wdata_q;
  logic                  if_ack_q;
  logic                  d_ack_q;
  logic [WORD_SIZE-1:0]  if_rdata_q;
  logic [WORD_SIZE-1:0]  d_rdata_q;
  logic                  busy_q;

  logic                  if_req_m;
  logic                  d_req_m;
  logic                  grant_d;
  logic                  gnt_data_d;

  // Arbitration: ignore the port being acked this cycle, break ties away from last grant.
  always_comb begin
    if_req_m   = if_req & ~if_ack_q;
    d_req_m    = d_req & ~d_ack_q;
    grant_d    = if_req_m | d_req_m;
    gnt_data_d = d_req_m & (~if_req_m | ~last_data_q);
  end

  // Access sequencer IDLE -> ACCESS -> RESP with registered strobes, data and acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      wr_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= gnt_data_d;
            wr_q        <= gnt_data_d & d_we;
            ram_we_q    <= gnt_data_d & d_we;
            ram_re_q    <= ~(gnt_data_d & d_we);
            ram_addr_q  <= gnt_data_d ? d_addr : if_addr;
            if (gnt_data_d) begin
              ram_wdata_q <= d_wdata;
            end
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!gnt_data_q) begin
            if_rdata_q <= ram_rdata;
            if_ack_q   <= 1'b1;
          end else begin
            if (!wr_q) begin
              d_rdata_q <= ram_rdata;
            end
            d_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule
